bht_ctrl: RTL and testbench

Controller for a table of 2-bit saturating branch predictor counters shared between a lookup requester (fetch) and an update requester (branch resolve). Sequences table initialisation after reset, arbitrates single-port table access between the two requesters, and buffers one pending update. Sits beside the per-branch predictor FSM and replaces it when many branches need independent prediction state.

---
 rtl/bht_ctrl_if.sv | 26 ++
 rtl/bht_ctrl.sv | 144 ++++++++++++++
 tb/tb_bht_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bht_ctrl_if.sv
// Lookup / update / status bundle between fetch, branch resolve and bht_ctrl.
// master = requester side, slave = bht_ctrl side.
interface bht_ctrl_if #(
    parameter int IDX_W = 4
);
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_ready;
    logic             pred_valid;
    logic             pred_taken;
    logic             up_valid;
    logic [IDX_W-1:0] up_idx;
    logic             up_taken;
    logic             up_ready;
    logic             init_done;

    modport master (
        output lk_valid, lk_idx, up_valid, up_idx, up_taken,
        input  lk_ready, pred_valid, pred_taken, up_ready, init_done
    );

    modport slave (
        input  lk_valid, lk_idx, up_valid, up_idx, up_taken,
        output lk_ready, pred_valid, pred_taken, up_ready, init_done
    );
endinterface

// File: rtl/bht_ctrl.sv
// Branch history table controller: 2**IDX_W two-bit saturating counters on a
// single-port table, swept to INIT_STATE after reset, with a one-entry update
// buffer drained by read-modify-write. Define GHIST_EN to XOR every table
// index with a global history register shifted on each drained update.
module bht_ctrl #(
    parameter int         IDX_W      = 4,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input logic       clk,
    input logic       rst,
    bht_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << IDX_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             init_done_q, init_done_d;
    logic             buf_vld_q, buf_vld_d;
    logic [IDX_W-1:0] buf_idx_q, buf_idx_d;
    logic             buf_tkn_q, buf_tkn_d;
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [1:0]       tbl_q [DEPTH];
    logic [1:0]       tbl_d [DEPTH];

    logic             lk_ready_w, up_ready_w;
    logic             lk_acc, up_acc;
    logic [IDX_W-1:0] lk_eff, dr_eff;

`ifdef GHIST_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;
`endif

    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else       return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

    // Handshake readiness and effective table indices from registered state
    always_comb begin
        lk_ready_w = (state_q == ST_RUN) && !buf_vld_q;
        up_ready_w = (state_q == ST_RUN) && !buf_vld_q;
        lk_acc     = bus.lk_valid && lk_ready_w;
        up_acc     = bus.up_valid && up_ready_w;
`ifdef GHIST_EN
        lk_eff     = bus.lk_idx ^ ghr_q;
        dr_eff     = buf_idx_q ^ ghr_q;
`else
        lk_eff     = bus.lk_idx;
        dr_eff     = buf_idx_q;
`endif
    end

    // Next state: init sweep, then one table access per cycle (drain wins over requests)
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        init_done_d  = init_done_q;
        buf_vld_d    = buf_vld_q;
        buf_idx_d    = buf_idx_q;
        buf_tkn_d    = buf_tkn_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        tbl_d        = tbl_q;
`ifdef GHIST_EN
        ghr_d        = ghr_q;
`endif
        case (state_q)
            ST_INIT: begin
                tbl_d[ptr_q] = INIT_STATE;
                ptr_d        = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                if (buf_vld_q) begin
                    tbl_d[dr_eff] = sat_next(tbl_q[dr_eff], buf_tkn_q);
                    buf_vld_d     = 1'b0;
`ifdef GHIST_EN
                    ghr_d         = {ghr_q[IDX_W-2:0], buf_tkn_q};
`endif
                end else begin
                    // Lookup samples the table before a same-cycle update lands
                    if (lk_acc) begin
                        pred_valid_d = 1'b1;
                        pred_taken_d = tbl_q[lk_eff][1];
                    end
                    if (up_acc) begin
                        buf_vld_d = 1'b1;
                        buf_idx_d = bus.up_idx;
                        buf_tkn_d = bus.up_taken;
                    end
                end
            end
        endcase
    end

    // Control registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            init_done_q  <= 1'b0;
            buf_vld_q    <= 1'b0;
            buf_idx_q    <= '0;
            buf_tkn_q    <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            init_done_q  <= init_done_d;
            buf_vld_q    <= buf_vld_d;
            buf_idx_q    <= buf_idx_d;
            buf_tkn_q    <= buf_tkn_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
        end
    end

`ifdef GHIST_EN
    // Global history register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ghr_q <= '0;
        else      ghr_q <= ghr_d;
    end
`endif

    // Counter table; contents are rebuilt by the init sweep, so no reset
    always_ff @(posedge clk) begin
        tbl_q <= tbl_d;
    end

    assign bus.lk_ready   = lk_ready_w;
    assign bus.up_ready   = up_ready_w;
    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_taken = pred_taken_q;
    assign bus.init_done  = init_done_q;
endmodule

// File: tb/tb_bht_ctrl.sv
// Self-checking bench for bht_ctrl: a behavioural counter-table model feeds a
// scoreboard of expected predictions; readiness is checked every cycle.
module tb_bht_ctrl;
    localparam int         IDX_W   = 4;
    localparam logic [1:0] INIT_ST = 2'b01;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bht_ctrl_if #(.IDX_W(IDX_W)) bif ();

    bht_ctrl #(.IDX_W(IDX_W), .INIT_STATE(INIT_ST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [1:0] m_tbl [16];
    logic [3:0] m_ghr;
    bit         run_m;
    bit         busy_m;
    logic       last_pt;
    logic       sb [$];
    int         dut_lk_cnt;
    int         dut_up_cnt;

    function automatic logic [3:0] m_eff(input logic [3:0] idx);
`ifdef GHIST_EN
        return idx ^ m_ghr;
`else
        return idx;
`endif
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = INIT_ST;
        m_ghr   = '0;
        run_m   = 1'b0;
        busy_m  = 1'b0;
        last_pt = 1'b0;
        sb.delete();
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1
    task automatic cyc(input bit lv, input logic [3:0] li, input bit uv,
                       input logic [3:0] ui, input bit ut);
        bit         rdy, lk_acc, up_acc;
        logic [3:0] e;
        logic       exp_pt;
        bif.lk_valid = lv;
        bif.lk_idx   = li;
        bif.up_valid = uv;
        bif.up_idx   = ui;
        bif.up_taken = ut;
        @(negedge clk);
        rdy = run_m && !busy_m;
        total++;
        if (bif.lk_ready !== rdy) begin
            bad++;
            $display("FAIL lk_ready: got %b expected %b", bif.lk_ready, rdy);
        end
        total++;
        if (bif.up_ready !== rdy) begin
            bad++;
            $display("FAIL up_ready: got %b expected %b", bif.up_ready, rdy);
        end
        if (lv && bif.lk_ready === 1'b1) dut_lk_cnt++;
        if (uv && bif.up_ready === 1'b1) dut_up_cnt++;
        lk_acc = lv && rdy;
        up_acc = uv && rdy;
        if (lk_acc) sb.push_back(m_tbl[m_eff(li)][1]);
        if (up_acc) begin
            e = m_eff(ui);
            if (ut) m_tbl[e] = (m_tbl[e] == 2'b11) ? 2'b11 : m_tbl[e] + 2'd1;
            else    m_tbl[e] = (m_tbl[e] == 2'b00) ? 2'b00 : m_tbl[e] - 2'd1;
            m_ghr = {m_ghr[2:0], ut};
        end
        busy_m = up_acc;
        @(posedge clk);
        #1;
        total++;
        if (bif.pred_valid !== lk_acc) begin
            bad++;
            $display("FAIL pred_valid: got %b expected %b", bif.pred_valid, lk_acc);
        end
        if (bif.pred_valid === 1'b1 && sb.size() > 0) begin
            exp_pt  = sb.pop_front();
            last_pt = exp_pt;
        end
        total++;
        if (bif.pred_taken !== last_pt) begin
            bad++;
            $display("FAIL pred_taken idx=%0d: got %b expected %b", li, bif.pred_taken, last_pt);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic lookup(input logic [3:0] idx);
        cyc(1'b1, idx, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic update(input logic [3:0] idx, input bit tk);
        cyc(1'b0, 4'd0, 1'b1, idx, tk);
        idle();
    endtask

    // Release reset at a falling edge and count edges until init_done
    task automatic do_init();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bif.init_done !== (i == 16)) begin
                bad++;
                $display("FAIL init_done edge %0d: got %b expected %b", i, bif.init_done, (i == 16));
            end
            total++;
            if (bif.lk_ready !== (i == 16)) begin
                bad++;
                $display("FAIL init lk_ready edge %0d: got %b expected %b", i, bif.lk_ready, (i == 16));
            end
        end
        run_m = 1'b1;
    endtask

    task automatic test_reset();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bif.pred_valid, bif.pred_taken, bif.init_done, bif.lk_ready, bif.up_ready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {bif.pred_valid, bif.pred_taken, bif.init_done, bif.lk_ready, bif.up_ready});
        end
        do_init();
    endtask

    task automatic test_init_lookup();
        lookup(4'd3);
        idle();
    endtask

    task automatic test_taken_sat();
        update(4'd5, 1'b1);
        update(4'd5, 1'b1);
        lookup(4'd5);
        update(4'd5, 1'b1);
        lookup(4'd5);
        update(4'd5, 1'b0);
        lookup(4'd5);
    endtask

    task automatic test_not_taken_sat();
        for (int i = 0; i < 3; i++) update(4'd7, 1'b0);
        update(4'd7, 1'b1);
        lookup(4'd7);
        lookup(4'd8);
    endtask

    task automatic test_simultaneous();
        cyc(1'b1, 4'd2, 1'b1, 4'd2, 1'b1);
        cyc(1'b1, 4'd2, 1'b1, 4'd2, 1'b1);
        idle();
        lookup(4'd2);
    endtask

    task automatic test_back_to_back();
        dut_lk_cnt = 0;
        dut_up_cnt = 0;
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'd11, 1'b1, 4'd10, 1'b0);
        idle();
        total++;
        if (dut_lk_cnt !== 4) begin
            bad++;
            $display("FAIL b2b_lookup_accepts: got %0d expected 4", dut_lk_cnt);
        end
        total++;
        if (dut_up_cnt !== 4) begin
            bad++;
            $display("FAIL b2b_update_accepts: got %0d expected 4", dut_up_cnt);
        end
        lookup(4'd10);
    endtask

    task automatic test_mid_reset();
        update(4'd9, 1'b1);
        update(4'd9, 1'b1);
        lookup(4'd9);
        cyc(1'b0, 4'd0, 1'b1, 4'd9, 1'b0);
        rst = 1'b0;
        #1;
        total++;
        if ({bif.pred_valid, bif.pred_taken, bif.init_done, bif.lk_ready, bif.up_ready} !== 5'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got %b expected 00000",
                     {bif.pred_valid, bif.pred_taken, bif.init_done, bif.lk_ready, bif.up_ready});
        end
        bif.up_valid = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        do_init();
        lookup(4'd9);
        idle();
    endtask

`ifdef GHIST_EN
    task automatic test_ghist();
        update(4'd0, 1'b1);
        update(4'd0, 1'b1);
        lookup(4'd3);
        idle();
    endtask
`endif

    initial begin
        bif.lk_valid = 1'b0;
        bif.lk_idx   = '0;
        bif.up_valid = 1'b0;
        bif.up_idx   = '0;
        bif.up_taken = 1'b0;
        test_reset();
        test_init_lookup();
        test_taken_sat();
        test_not_taken_sat();
        test_simultaneous();
        test_back_to_back();
        test_mid_reset();
`ifdef GHIST_EN
        test_mid_reset();
        test_ghist();
`endif
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
